// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    localparam int MEM_LAT_DEF = 1;
    localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Simulation-only protocol checks for the arbiter's requester handshakes.
module mem_port_arbiter_chk (
    input logic clk,
    input logic rst_n,
    input logic if_req,
    input logic if_ready,
    input logic d_req,
    input logic d_ready
);

    if_req_held_a: assert property (@(posedge clk) disable iff (!rst_n)
        (if_req && !if_ready) |=> if_req)
        else $error("if_req withdrawn before if_ready");

    d_req_held_a: assert property (@(posedge clk) disable iff (!rst_n)
        (d_req && !d_ready) |=> d_req)
        else $error("d_req withdrawn before d_ready");

    ready_exclusive_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(if_ready && d_ready))
        else $error("if_ready and d_ready asserted together");

endmodule

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear wins, increment stops at the all-ones ceiling.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access,
// data first, alternating under contention, each grant lasting MEM_LAT cycles.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 64,
    parameter int INST_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [INST_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] p_addr,
    output logic              p_we,
    output logic [DATA_W-1:0] p_wdata,
    input  logic [DATA_W-1:0] p_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_LAT - 1);

    arb_state_e        state_r, state_s;
    logic [WAIT_W-1:0] wait_r, wait_s;
    logic              last_served_r, last_served_s;  // 1 = data side holds/held the port
    logic [INST_W-1:0] if_hold_r;
    logic [DATA_W-1:0] d_hold_r;
    logic              last_s;
    logic              fetch_done_s;
    logic              load_done_s;
    logic              conflict_s;

    assign last_s = (wait_r == LAST_WAIT);

    // State, wait counter, last-served flag and read-data holding registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            wait_r        <= {WAIT_W{1'b0}};
            last_served_r <= 1'b0;
            if_hold_r     <= {INST_W{1'b0}};
            d_hold_r      <= {DATA_W{1'b0}};
        end else begin
            state_r       <= state_s;
            wait_r        <= wait_s;
            last_served_r <= last_served_s;
            if (fetch_done_s) begin
                if_hold_r <= p_rdata[INST_W-1:0];
            end
            if (load_done_s) begin
                d_hold_r <= p_rdata;
            end
        end
    end

    // Next-state: the served requester's req is stale in its last grant cycle,
    // so only the other side can chain straight into a new grant.
    always_comb begin
        state_s       = state_r;
        wait_s        = {WAIT_W{1'b0}};
        last_served_s = last_served_r;
        case (state_r)
            IDLE: begin
                if (d_req) begin
                    state_s       = GNT_D;
                    last_served_s = 1'b1;
                end else if (if_req) begin
                    state_s       = GNT_I;
                    last_served_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            GNT_I, GNT_D: begin
                if (!last_s) begin
                    wait_s = wait_r + WAIT_W'(1'b1);
                end else if (last_served_r) begin
                    if (if_req) begin
                        state_s       = GNT_I;
                        last_served_s = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    if (d_req) begin
                        state_s       = GNT_D;
                        last_served_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Outputs: port drive for the whole grant, ready/commit/bypass only in its last cycle.
    always_comb begin
        if_ready     = 1'b0;
        d_ready      = 1'b0;
        p_we         = 1'b0;
        p_addr       = {ADDR_W{1'b0}};
        p_wdata      = {DATA_W{1'b0}};
        if_rdata     = if_hold_r;
        d_rdata      = d_hold_r;
        fetch_done_s = 1'b0;
        load_done_s  = 1'b0;
        conflict_s   = 1'b0;
        if (rst_n) begin
            case (state_r)
                GNT_I: begin
                    p_addr = if_addr;
                    if (last_s) begin
                        if_ready     = 1'b1;
                        if_rdata     = p_rdata[INST_W-1:0];
                        fetch_done_s = 1'b1;
                    end else begin
                        conflict_s = d_req;
                    end
                end
                GNT_D: begin
                    p_addr  = d_addr;
                    p_wdata = d_wdata;
                    if (last_s) begin
                        d_ready = 1'b1;
                        p_we    = d_we;
                        if (!d_we) begin
                            d_rdata     = p_rdata;
                            load_done_s = 1'b1;
                        end else begin
                            load_done_s = 1'b0;
                        end
                    end else begin
                        conflict_s = if_req;
                    end
                end
                default: begin
                    p_addr = {ADDR_W{1'b0}};
                end
            endcase
        end else begin
            conflict_s = 1'b0;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_conflict_cnt (
        .clk (clk),
        .clr (!rst_n),
        .inc (conflict_s),
        .cnt (conflict_cnt)
    );

endmodule
